serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: Diff = A - B - Bin (modulo 2^WIDTH), one bit
// per clock, LSB first. A borrow flip-flop carries the borrow from one bit to
// the next. A start/busy/done handshake connects the block to a controlling FSM.
//
// Parameters
//   WIDTH  operand and result width in bits (>= 1)
//
// Ports
//   clk    rising-edge clock (the only clock domain)
//   rst    synchronous, active-high reset; takes priority over every input
//   start  request; sampled only while idle, ignored while running
//   A      minuend, captured on the accepting edge
//   B      subtrahend, captured on the accepting edge
//   Bin    borrow-in, captured on the accepting edge
//   busy   high while bits are being processed (state == RUN)
//   done   one-cycle pulse; Diff/Bout carry the new result in that cycle
//   Diff   difference modulo 2^WIDTH, held until the next completion or reset
//   Bout   final borrow; 1 iff A < B + Bin (unsigned)
//
// Latency from the accepting edge to the done cycle is WIDTH clocks. Partial
// results build up in an internal shift register. They are copied to Diff
// only on the last bit, so intermediate bits never appear on the output.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  // The bit counter needs at least one bit, so that WIDTH=1 still has a valid
  // register. RUN ends on the edge where the counter reaches WIDTH-1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One-bit full subtractor. Returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bin);
    logic d;
    logic bo;
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
    return {bo, d};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] d_sr_r;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;

  logic [1:0]       bit_s;      // {borrow_next, d} for the current bit
  logic [WIDTH-1:0] d_shift_s;  // d_sr after shifting in the current bit

  // Current bit of the subtraction, and the result register after that bit
  // is shifted into its MSB. On the last bit, d_shift_s is the full result.
  always_comb begin
    bit_s                = sub_bit(a_sr_r[0], b_sr_r[0], borrow_r);
    d_shift_s            = d_sr_r >> 1'b1;
    d_shift_s[WIDTH-1]   = bit_s[0];
  end

  // Control FSM and datapath registers. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      d_sr_r   <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      bout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // done is a single-cycle pulse. It drops even when no new request arrives.
          done_r <= 1'b0;
          if (start) begin
            a_sr_r   <= A;
            b_sr_r   <= B;
            borrow_r <= Bin;
            d_sr_r   <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end

        RUN: begin
          // start is not looked at here. Requests made while running are dropped.
          a_sr_r   <= a_sr_r >> 1'b1;
          b_sr_r   <= b_sr_r >> 1'b1;
          d_sr_r   <= d_shift_s;
          borrow_r <= bit_s[1];
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_BIT) begin
            diff_r  <= d_shift_s;
            bout_r  <= bit_s[1];
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign Diff = diff_r;
  assign Bout = bout_r;

endmodule
